// File: rtl/spectrum_log_mag.sv
// FFT bin stream to 8-bit log2 magnitude-squared codes for the waterfall buffer.
// Four-stage pipeline: square, sum, leading-one log, floor/gain; first OUT_BINS bins per frame kept.

module spectrum_log_code #(
    parameter int MW = 32
) (
    input  logic [MW-1:0] mag2,
    output logic [7:0]    code
);
    // mag2 shifted up by 3 so the three bits under any leading one are addressable
    logic [MW+1:0] ext;
    int            p;
    logic [2:0]    frac;
    int            cv;

    assign ext = {mag2[MW-2:0], 3'b000};

    always_comb begin
        p    = 0;
        frac = 3'b000;
        for (int i = 0; i < MW; i++) begin
            if (mag2[i]) begin
                p    = i;
                frac = {ext[i+2], ext[i+1], ext[i]};
            end
        end
        cv   = 8 * p + int'(frac);
        code = (cv > 255) ? 8'hFF : cv[7:0];
    end
endmodule

module spectrum_log_mag #(
    parameter int N_FFT      = 1024,
    parameter int OUT_BINS   = 512,
    parameter int IN_WIDTH   = 16,
    parameter int FLOOR      = 0,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic signed [IN_WIDTH-1:0] fft_re,
    input  logic signed [IN_WIDTH-1:0] fft_im,
    input  logic                       fft_valid,
    input  logic                       fft_last,
    output logic [7:0]                 log_out,
    output logic                       log_valid,
    output logic                       log_last,
    output logic                       frame_err
);
    localparam int MW     = 2 * IN_WIDTH;
    localparam int BW     = (N_FFT > 1) ? $clog2(N_FFT) : 1;
    localparam int STAGES = 4;

    localparam logic [BW:0]   OUT_LIM = (BW+1)'(OUT_BINS);
    localparam logic [BW-1:0] OUT_END = BW'(OUT_BINS - 1);
    localparam logic [BW-1:0] BIN_END = BW'(N_FFT - 1);

    logic [BW-1:0] in_bin;
    logic          bin_end;
    logic          in_fwd;
    logic          in_last;
    logic          in_err;

    // Flags ride alongside the data; bit STAGES-1 is the output slot
    logic [STAGES-1:0] vld_pipe;
    logic [STAGES-1:0] last_pipe;
    logic [STAGES-1:0] err_pipe;

    logic signed [MW-1:0] re_x, im_x;
    logic [MW-1:0]        sq_re, sq_im;
    logic [MW-1:0]        mag2;
    logic [7:0]           code_c, code_q;
    logic [7:0]           lvl;
    int                   scaled;

    assign bin_end = (in_bin == BIN_END);
    assign in_fwd  = fft_valid && ({1'b0, in_bin} < OUT_LIM);
    assign in_last = in_fwd && (fft_last || (in_bin == OUT_END));
    // Short frame (early last) and long frame (missing last) both flag here
    assign in_err  = fft_valid && (fft_last != bin_end);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_bin    <= '0;
            vld_pipe  <= '0;
            last_pipe <= '0;
            err_pipe  <= '0;
            log_out   <= '0;
        end else begin
            if (fft_valid)
                in_bin <= (fft_last || bin_end) ? '0 : in_bin + 1'b1;
            vld_pipe  <= {vld_pipe[STAGES-2:0], in_fwd};
            last_pipe <= {last_pipe[STAGES-2:0], in_last};
            err_pipe  <= {err_pipe[STAGES-2:0], in_err};
            if (vld_pipe[STAGES-2])
                log_out <= lvl;
        end
    end

    assign log_valid = vld_pipe[STAGES-1];
    assign log_last  = last_pipe[STAGES-1];
    assign frame_err = err_pipe[STAGES-1];

    assign re_x = MW'(fft_re);
    assign im_x = MW'(fft_im);

    // Datapath needs no reset: qualified by the flag pipes above
    always_ff @(posedge clk) begin
        sq_re  <= $unsigned(re_x * re_x);
        sq_im  <= $unsigned(im_x * im_x);
        mag2   <= sq_re + sq_im;
        code_q <= code_c;
    end

    spectrum_log_code #(.MW(MW)) u_code (
        .mag2 (mag2),
        .code (code_c)
    );

    always_comb begin
        scaled = 0;
        lvl    = 8'h00;
        if (int'(code_q) > FLOOR) begin
            scaled = (int'(code_q) - FLOOR) <<< GAIN_SHIFT;
            lvl    = (scaled > 255) ? 8'hFF : scaled[7:0];
        end
    end
endmodule

// File: doc/spectrum_log_mag.md
Name: spectrum_log_mag

Overview:
- Upstream neighbour of the waterfall frame buffer.
- Consumes the complex FFT output stream, one bin per valid cycle, and computes a fixed-point log2 of magnitude-squared.
- Applies floor and gain, and keeps only the first OUT_BINS bins of each frame.
- Drives the buffer's 8-bit log sample / valid / last write interface; one output frame becomes one waterfall row.

Parameters:
- N_FFT, 1024, input frame length in bins; power of two.
- OUT_BINS, 512, bins forwarded per frame; must be ≤ N_FFT.
- IN_WIDTH, 16, signed width of fft_re and fft_im.
- FLOOR, 0, log code (0..255) subtracted before gain; codes ≤ FLOOR give 0.
- GAIN_SHIFT, 0, left shift applied after floor subtraction (0..7).

Ports:
- clk  in  1  single clock domain
- rst_n  in  1  asynchronous active-low reset
- fft_re  in  IN_WIDTH  signed real part of current bin
- fft_im  in  IN_WIDTH  signed imaginary part of current bin
- fft_valid  in  1  bin present this cycle; no backpressure
- fft_last  in  1  qualifies the final bin of an FFT frame
- log_out  out  8  log-magnitude code
- log_valid  out  1  log_out valid this cycle
- log_last  out  1  final forwarded bin of the frame
- frame_err  out  1  one-cycle pulse on frame length violation

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - rst_n low clears the bin counter, all pipeline valid/last flags, log_out, log_valid, log_last and frame_err to 0.
  - Reset is asynchronous assert, synchronous deassert handled externally.
  - Reset mid-frame discards in-flight samples. The first fft_valid after release is bin 0.
- Input bin counter in_bin, width clog2(N_FFT):
  - Increments on each fft_valid.
  - Returns to 0 on fft_valid with fft_last, or after bin N_FFT-1.
- Forwarding:
  - A bin is forwarded iff in_bin < OUT_BINS.
  - A forwarded bin carries last=1 iff in_bin == OUT_BINS-1.
  - A forwarded bin also carries last=1 if it has fft_last with in_bin < OUT_BINS-1 (short frame).
  - Bins ≥ OUT_BINS produce no output.
- Frame errors: frame_err pulses, aligned with that bin's output slot, when:
  - fft_last arrives with in_bin != N_FFT-1 (short frame), or
  - in_bin == N_FFT-1 without fft_last (long frame; the counter still wraps to 0).
- Pipeline: fixed 4-cycle latency from fft_valid to log_valid; valid, last and err travel in parallel shift registers. fft_valid may be asserted every cycle; throughput is 1 bin/cycle.
  - S1: register re² and im², each 2*IN_WIDTH-bit unsigned.
  - S2: mag2 = re² + im², 2*IN_WIDTH bits unsigned. No overflow: max is 2^(2*IN_WIDTH-1).
  - S3: p = index of the leading one of mag2 (0..2*IN_WIDTH-1).
    - frac = the 3 bits immediately below the leading one; bit positions below 0 read as 0.
    - code = 8*p + frac, saturated to 255.
    - mag2 == 0 gives code 0.
  - S4: if code ≤ FLOOR then log_out=0; else log_out = min(255, (code-FLOOR) << GAIN_SHIFT).
- Output fields: log_out is held between valids; log_valid and log_last are 0 when idle.
- Timing: no combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- Zero and pure input, defaults: re=0,im=0 -> log_out=0; re=3,im=4 (mag2=25) -> 36; re=16384,im=0 -> 224; re=-32768,im=-32768 -> 248, each exactly 4 cycles after fft_valid.
- Full frame: 1024 back-to-back bins, fft_last on bin 1023 -> exactly 512 log_valid pulses, log_last only on the 512th, frame_err never asserted; second frame repeats identically.
- Floor/gain, FLOOR=200, GAIN_SHIFT=2: mag2=2^28 (code 224) -> 96; code 200 -> 0; code 255 -> 220; with GAIN_SHIFT=3, code 255 -> 255 (saturated).
- Short frame: fft_last on bin 99 -> log_last on output 100, frame_err pulse; next valid is bin 0. fft_last on bin 700 -> no output for it, frame_err pulse.
- Long frame: 1024 bins with no fft_last -> frame_err pulse at bin 1023; bin 1024 is treated as bin 0 and forwarded.
- Reset mid-frame: assert rst_n=0 at bin 300 with 3 samples in flight -> all outputs 0 immediately, no stale log_valid after release; the next frame starts at bin 0 with correct log_last at 512.
